fb_write_arbiter: RTL and testbench

- Sole owner of the frame buffer's GPU-side write port (17-bit address, 4-bit pixel, write enable).
- Shares that port between two pixel requesters (rasterizer, blitter) using valid/ready handshakes and round-robin arbitration.
- Contains a built-in clear sequencer that fills all 76800 pixels with one colour.
- Rejects out-of-range addresses so they can never reach the buffer.

---
 rtl/fb_write_arbiter.sv | 139 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port owner: round-robin arbitration between two pixel requesters,
// a full-buffer clear sequencer, and out-of-range address rejection.
module fb_write_arbiter #(
  parameter int NUM_PIXELS = 76800,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 4
) (
  input  logic              gpu_clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              oob_err,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_we
);

  // Handshake: a requester transfers on any cycle where valid && ready are both high;
  // valid with addr/data must stay stable until then, ready never depends on a later cycle.

  typedef enum logic {ST_ARB, ST_CLEAR} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W:0]   NUM_P     = (ADDR_W + 1)'(NUM_PIXELS);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   clr_color_q, clr_color_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0]   fb_data_q, fb_data_d;
  logic                fb_we_q, fb_we_d;
  logic                clear_done_q, clear_done_d;
  logic                oob_q, oob_d;

  logic                grant0, grant1, arb_open, hs0, hs1, in_range;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // On a tie the requester that did not win last time gets the port.
  assign grant0   = req0_valid && (!req1_valid || last_grant_q);
  assign grant1   = req1_valid && (!req0_valid || !last_grant_q);
  assign arb_open = !rst && (state_q == ST_ARB) && !clear_start;

  assign req0_ready = arb_open && grant0;
  assign req1_ready = arb_open && grant1;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  assign sel_addr = hs1 ? req1_addr : req0_addr;
  assign sel_data = hs1 ? req1_data : req0_data;
  assign in_range = {1'b0, sel_addr} < NUM_P;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    clr_cnt_d    = clr_cnt_q;
    clr_color_d  = clr_color_q;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    fb_we_d      = 1'b0;
    clear_done_d = 1'b0;
    oob_d        = oob_q;
    case (state_q)
      ST_ARB: begin
        if (clear_start) begin
          state_d     = ST_CLEAR;
          clr_cnt_d   = '0;
          clr_color_d = clear_color;
        end else if (hs0 || hs1) begin
          last_grant_d = hs1;
          // Out-of-range writes are accepted from the requester but never reach the buffer.
          if (in_range) begin
            fb_we_d   = 1'b1;
            fb_addr_d = sel_addr;
            fb_data_d = sel_data;
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        fb_we_d   = 1'b1;
        fb_addr_d = clr_cnt_q;
        fb_data_d = clr_color_q;
        if (clr_cnt_q == LAST_ADDR) begin
          clear_done_d = 1'b1;
          state_d      = ST_ARB;
          clr_cnt_d    = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ARB;
      last_grant_q <= 1'b1;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_we_q      <= 1'b0;
      clear_done_q <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      fb_we_q      <= fb_we_d;
      clear_done_q <= clear_done_d;
      oob_q        <= oob_d;
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = clear_done_q;
  assign oob_err    = oob_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios plus random traffic, all checked each
// cycle against a transaction-level model of the write port.
module tb_fb_write_arbiter;

  localparam int NUM = 76800;

  logic        gpu_clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [16:0] req0_addr, req1_addr;
  logic [3:0]  req0_data, req1_data;
  logic        clear_start;
  logic [3:0]  clear_color;
  logic        clear_busy, clear_done, oob_err, fb_we;
  logic [16:0] fb_addr;
  logic [3:0]  fb_data;

  int total = 0;
  int bad   = 0;

  fb_write_arbiter dut (
    .gpu_clk(gpu_clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done), .oob_err(oob_err),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
  );

  // clock / reset
  initial gpu_clk = 1'b0;
  always #5 gpu_clk = ~gpu_clk;

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h req=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: act=expired req=event at %0t", name, $time);
  endtask

  // behavioural model: port owner is either serving requesters or walking a fill index
  logic        m_clearing;
  int          m_idx;
  logic [3:0]  m_color;
  int          m_last;
  logic        m_oob;
  logic        exp_we, exp_done, exp_src_req;
  int          exp_addr, exp_data;
  logic [20:0] exp_q[$];

  always @(negedge gpu_clk) begin
    int g;
    int a, d;
    if (rst) begin
      m_clearing = 0; m_idx = 0; m_color = 0; m_last = 1; m_oob = 0;
      exp_we = 0; exp_done = 0; exp_src_req = 0; exp_addr = 0; exp_data = 0;
      exp_q.delete();
      chk("rst_we", fb_we, 0);
      chk("rst_addr", fb_addr, 0);
      chk("rst_data", fb_data, 0);
      chk("rst_done", clear_done, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_oob", oob_err, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
    end else begin
      chk("m_we", fb_we, exp_we);
      chk("m_addr", fb_addr, exp_addr);
      chk("m_data", fb_data, exp_data);
      chk("m_done", clear_done, exp_done);
      chk("m_busy", clear_busy, m_clearing);
      chk("m_oob", oob_err, m_oob);
      if (fb_we === 1'b1 && exp_src_req) begin
        if (exp_q.size() == 0) fail_now("sb_empty");
        else chk("sb_write", {11'b0, fb_addr, fb_data}, {11'b0, exp_q.pop_front()});
      end
      g = -1;
      if (!m_clearing && !clear_start) begin
        if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
      end
      chk("m_ready0", req0_ready, (g == 0));
      chk("m_ready1", req1_ready, (g == 1));
      exp_done = 0; exp_we = 0; exp_src_req = 0;
      if (m_clearing) begin
        exp_we = 1; exp_addr = m_idx; exp_data = m_color;
        if (m_idx == NUM - 1) begin
          exp_done = 1; m_clearing = 0;
        end else begin
          m_idx++;
        end
      end else if (clear_start) begin
        m_clearing = 1; m_idx = 0; m_color = clear_color;
      end else if (g >= 0) begin
        m_last = g;
        a = (g == 1) ? int'(req1_addr) : int'(req0_addr);
        d = (g == 1) ? int'(req1_data) : int'(req0_data);
        if (a < NUM) begin
          exp_we = 1; exp_src_req = 1; exp_addr = a; exp_data = d;
          exp_q.push_back({a[16:0], d[3:0]});
        end else begin
          m_oob = 1;
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge gpu_clk);
    #1;
  endtask

  function automatic logic [16:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return 17'($urandom_range(NUM, 131071));
    return 17'($urandom_range(0, NUM - 1));
  endfunction

  task automatic run_random(input int n);
    logic h0, h1;
    for (int i = 0; i < n + 10; i++) begin
      @(negedge gpu_clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      next_cycle();
      if (i < n) begin
        if (!req0_valid || h0) begin
          req0_valid = ($urandom_range(0, 3) != 0);
          req0_addr  = rand_addr();
          req0_data  = 4'($urandom_range(0, 15));
        end
        if (!req1_valid || h1) begin
          req1_valid = ($urandom_range(0, 3) != 0);
          req1_addr  = rand_addr();
          req1_data  = 4'($urandom_range(0, 15));
        end
      end else begin
        if (h0) req0_valid = 1'b0;
        if (h1) req1_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int  count;
    logic seen_done, pulsed, pulse_now, found;
    rst = 1'b1;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    clear_start = 0; clear_color = 0;
    repeat (3) @(posedge gpu_clk);
    @(negedge gpu_clk);
    chk("reset_we", fb_we, 0);
    chk("reset_busy", clear_busy, 0);
    next_cycle();
    rst = 1'b0;

    // single write from requester 0
    req0_valid = 1; req0_addr = 17'd5; req0_data = 4'hA;
    @(negedge gpu_clk);
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    next_cycle();
    req0_valid = 0;
    @(negedge gpu_clk);
    chk("t1_we", fb_we, 1);
    chk("t1_addr", fb_addr, 5);
    chk("t1_data", fb_data, 4'hA);
    @(negedge gpu_clk);
    chk("t1_we_off", fb_we, 0);
    chk("t1_addr_hold", fb_addr, 5);

    // requester 1 alone so that the next tie goes to requester 0
    next_cycle();
    req1_valid = 1; req1_addr = 17'd1; req1_data = 4'h1;
    next_cycle();
    req0_valid = 1; req0_addr = 17'd10; req0_data = 4'h4;
    req1_valid = 1; req1_addr = 17'd20; req1_data = 4'h6;
    for (int i = 0; i < 4; i++) begin
      @(negedge gpu_clk);
      chk("t2_grant", {30'b0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) begin
        chk("t2_fb_we", fb_we, 1);
        chk("t2_fb_addr", fb_addr, (i % 2 == 1) ? 32'd10 : 32'd20);
      end
      next_cycle();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge gpu_clk);
    chk("t2_fb_addr_last", fb_addr, 20);

    // out-of-range request from requester 1
    next_cycle();
    req1_valid = 1; req1_addr = 17'd76800; req1_data = 4'h3;
    @(negedge gpu_clk);
    chk("t3_ready1", req1_ready, 1);
    next_cycle();
    req1_valid = 0;
    @(negedge gpu_clk);
    chk("t3_we", fb_we, 0);
    chk("t3_oob", oob_err, 1);
    next_cycle();
    req0_valid = 1; req0_addr = 17'd7; req0_data = 4'h9;
    next_cycle();
    req0_valid = 0;
    @(negedge gpu_clk);
    chk("t3_after_we", fb_we, 1);
    chk("t3_after_addr", fb_addr, 7);
    chk("t3_oob_sticky", oob_err, 1);

    // full clear, requester 0 waiting, second clear_start ignored
    next_cycle();
    clear_start = 1; clear_color = 4'h7;
    req0_valid = 1; req0_addr = 17'd9; req0_data = 4'h2;
    @(negedge gpu_clk);
    chk("t4_ready0", req0_ready, 0);
    next_cycle();
    clear_start = 0; clear_color = 4'h3;
    count = 0; seen_done = 0; pulsed = 0;
    for (int c = 0; c < NUM + 20 && !seen_done; c++) begin
      @(negedge gpu_clk);
      pulse_now = 0;
      if (fb_we) count++;
      if (clear_done) begin
        seen_done = 1;
        chk("t4_last_addr", fb_addr, NUM - 1);
        chk("t4_last_data", fb_data, 7);
        chk("t4_ready_at_done", req0_ready, 1);
        chk("t4_busy_at_done", clear_busy, 0);
        chk("t4_count", count, NUM);
      end else if (!pulsed && fb_we && fb_addr == 17'd100) begin
        pulsed = 1; pulse_now = 1;
      end
      next_cycle();
      clear_start = pulse_now;
      if (seen_done) req0_valid = 0;
    end
    if (!seen_done) fail_now("t4_done_timeout");
    @(negedge gpu_clk);
    chk("t4_req_we", fb_we, 1);
    chk("t4_req_addr", fb_addr, 9);
    chk("t4_req_data", fb_data, 2);

    // reset in the middle of a clear
    next_cycle();
    clear_start = 1; clear_color = 4'h5;
    next_cycle();
    clear_start = 0;
    found = 0;
    for (int c = 0; c < 3100 && !found; c++) begin
      @(negedge gpu_clk);
      if (fb_we && fb_addr == 17'd3000) found = 1;
    end
    if (!found) fail_now("t5_addr_timeout");
    #2 rst = 1'b1;
    #1;
    chk("t5_we", fb_we, 0);
    chk("t5_addr", fb_addr, 0);
    chk("t5_busy", clear_busy, 0);
    chk("t5_done", clear_done, 0);
    repeat (2) @(posedge gpu_clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge gpu_clk);
      chk("t5_no_done", clear_done, 0);
    end
    next_cycle();
    req1_valid = 1; req1_addr = 17'd50; req1_data = 4'h5;
    @(negedge gpu_clk);
    chk("t5_ready1", req1_ready, 1);
    next_cycle();
    req1_valid = 0;
    @(negedge gpu_clk);
    chk("t5_we_after", fb_we, 1);
    chk("t5_addr_after", fb_addr, 50);
    chk("t5_data_after", fb_data, 5);

    run_random(1500);
    @(negedge gpu_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
